// File: rtl/anc_i2s_tx.sv
// anc_i2s_tx -- output end of the ANC datapath.
//
// Buffers signed anti-noise samples in a small FIFO and serialises them to an
// I2S DAC as mono frames (left = right = sample), 2*WIDTH slots per frame.
// Frame rate fs = f_clk / (4*WIDTH*SCLK_DIV).
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous reset, active high
//   ready_in        1-cycle strobe, sample_in valid
//   sample_in       signed anti-noise sample (passed bit-exact)
//   sclk_out        I2S bit clock
//   lrclk_out       I2S word select (0 = left, 1 = right)
//   sdata_out       I2S serial data, MSB first, one slot behind lrclk
//   fifo_level_out  entries currently held in the FIFO
//   overflow_out    1-cycle pulse: sample dropped because the FIFO was full
//   underflow_out   1-cycle pulse: frame started with the FIFO empty (mute)
module anc_i2s_tx #(
    parameter int WIDTH      = 16,
    parameter int SCLK_DIV   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             ready_in,
    input  logic [WIDTH-1:0] sample_in,
    output logic             sclk_out,
    output logic             lrclk_out,
    output logic             sdata_out,
    output logic [2:0]       fifo_level_out,
    output logic             overflow_out,
    output logic             underflow_out
);
    localparam int SLOTS = 2 * WIDTH;
    localparam int SW    = $clog2(SLOTS);
    localparam int DW    = $clog2(SCLK_DIV);
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    logic [DW-1:0]    div_cnt;
    logic [SW-1:0]    slot;
    logic [SLOTS-1:0] shift_q;
    logic             delay_q;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    logic             tc, fall, frame_start;
    logic [SW-1:0]    slot_nxt;
    logic             empty, full, pop, push;
    logic [SLOTS-1:0] shift_src;

    always_comb begin
        tc          = (div_cnt == DW'(SCLK_DIV - 1));
        // Only the 1->0 toggle of sclk advances the frame.
        fall        = tc && sclk_out;
        slot_nxt    = (slot == SW'(SLOTS - 1)) ? '0 : slot + 1'b1;
        frame_start = fall && (slot_nxt == '0);
        empty       = (count == '0);
        full        = (count == CW'(FIFO_DEPTH));
        // Pop sees pre-push contents, so a push into an empty FIFO cannot
        // feed the frame starting on the same cycle.
        pop         = frame_start && !empty;
        // A pop frees the slot a coincident push needs when full.
        push        = ready_in && (!full || pop);
        shift_src   = shift_q;
        if (frame_start)
            shift_src = pop ? {mem[rd_ptr], mem[rd_ptr]} : '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_cnt       <= '0;
            sclk_out      <= 1'b0;
            slot          <= SW'(SLOTS - 1);
            lrclk_out     <= 1'b0;
            sdata_out     <= 1'b0;
            delay_q       <= 1'b0;
            shift_q       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            div_cnt <= tc ? '0 : div_cnt + 1'b1;
            if (tc) sclk_out <= ~sclk_out;

            overflow_out  <= ready_in && full && !pop;
            underflow_out <= frame_start && empty;

            if (fall) begin
                slot      <= slot_nxt;
                lrclk_out <= (slot_nxt >= SW'(WIDTH));
                // Delay register gives the one-slot I2S data lag behind lrclk.
                sdata_out <= delay_q;
                delay_q   <= shift_src[SLOTS-1];
                shift_q   <= shift_src << 1;
            end

            if (push) begin
                mem[wr_ptr] <= sample_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign fifo_level_out = 3'(count);
endmodule

// File: tb/tb_anc_i2s_tx.sv
// Bench for anc_i2s_tx at SCLK_DIV=2. A monitor watches the I2S pins, tracks
// the slot number from observed sclk falls, keeps a reference FIFO, and
// scores every decoded frame against the word expected for it.
module tb_anc_i2s_tx;
    localparam int W = 16, DIV = 2, DEPTH = 4, FRAME = 2 * W * 2 * DIV;

    logic         clk_in = 1'b0;
    logic         rst_in, ready_in;
    logic [W-1:0] sample_in;
    logic         sclk_out, lrclk_out, sdata_out, overflow_out, underflow_out;
    logic [2:0]   fifo_level_out;

    int n_cmp = 0, n_err = 0;

    anc_i2s_tx #(.WIDTH(W), .SCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .ready_in       (ready_in),
        .sample_in      (sample_in),
        .sclk_out       (sclk_out),
        .lrclk_out      (lrclk_out),
        .sdata_out      (sdata_out),
        .fifo_level_out (fifo_level_out),
        .overflow_out   (overflow_out),
        .underflow_out  (underflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    // reference state
    logic [W-1:0] mq[$];     // model FIFO
    logic [W-1:0] exp_q[$];  // expected word per frame in flight
    int           bslot = 2 * W - 1;
    int           since = 0;
    bit           fvalid = 0;
    bit           fall_now = 0;
    logic         prev_sclk = 0, prev_sdata = 0, prev_lr = 0;
    logic [W-1:0] lw = '0, rw = '0, fw = '0;

    always @(posedge clk_in) begin
        logic         ri, rs, fall, pop, mute, ovf_exp;
        logic [W-1:0] si;
        ri = ready_in; rs = rst_in; si = sample_in;
        #1;
        fall_now = 0;
        if (rs) begin
            chk("rst_outs", {sclk_out, lrclk_out, sdata_out, overflow_out,
                             underflow_out, fifo_level_out}, 0);
            mq.delete(); exp_q.delete();
            bslot = 2 * W - 1; since = 0; fvalid = 0;
            prev_sclk = 0; prev_sdata = 0; prev_lr = 0;
        end else begin
            since++;
            fall = prev_sclk && !sclk_out;
            pop = 0; mute = 0;
            if (fall) begin
                fall_now = 1;
                chk("sclk_period", since, 2 * DIV);
                since = 0;
                bslot = (bslot + 1) % (2 * W);
                chk("lrclk", lrclk_out, (bslot >= W));
                if (bslot >= 1 && bslot <= W) lw[W - bslot] = sdata_out;
                else if (bslot > W)           rw[2 * W - bslot] = sdata_out;
                else begin
                    rw[0] = sdata_out;
                    if (fvalid && exp_q.size() > 0) begin
                        fw = exp_q.pop_front();
                        chk("left", lw, fw);
                        chk("right", rw, fw);
                    end
                    if (mq.size() > 0) begin fw = mq.pop_front(); pop = 1; end
                    else begin fw = '0; mute = 1; end
                    exp_q.push_back(fw);
                    fvalid = 1;
                end
            end else begin
                chk("sdata_hold", sdata_out, prev_sdata);
                chk("lrclk_hold", lrclk_out, prev_lr);
            end
            chk("underflow", underflow_out, mute);
            ovf_exp = 0;
            if (ri) begin
                if (mq.size() < DEPTH || pop) mq.push_back(si);
                else ovf_exp = 1;
            end
            chk("overflow", overflow_out, ovf_exp);
            chk("level", fifo_level_out, mq.size());
            prev_sclk = sclk_out; prev_sdata = sdata_out; prev_lr = lrclk_out;
        end
    end

    task automatic wait_slot(input int s);
        bit hit = 0;
        for (int i = 0; i < 3 * FRAME && !hit; i++) begin
            @(negedge clk_in);
            if (fall_now && bslot == s) hit = 1;
        end
        chk("slot_wait", hit, 1);
    endtask

    task automatic push(input logic [W-1:0] v);
        ready_in = 1'b1; sample_in = v;
        @(negedge clk_in);
        ready_in = 1'b0;
    endtask

    // drive ready_in on exactly the edge whose sclk fall starts slot 0
    task automatic push_at_frame_start(input logic [W-1:0] v);
        wait_slot(2 * W - 1);
        repeat (2 * DIV - 1) @(negedge clk_in);
        push(v);
    endtask

    initial begin
        rst_in = 1'b1; ready_in = 1'b0; sample_in = '0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        // idle: mute frames with underflow each frame
        repeat (2 * FRAME) @(negedge clk_in);

        // single sample, then mute
        wait_slot(5);
        push(16'hA5C3);
        repeat (3 * FRAME) @(negedge clk_in);

        // overflow: 5 back-to-back strobes well away from a frame start
        wait_slot(2);
        for (int i = 1; i <= 5; i++) begin
            ready_in = 1'b1; sample_in = W'(i);
            @(negedge clk_in);
        end
        ready_in = 1'b0;
        repeat (5 * FRAME) @(negedge clk_in);

        // most negative sample, bit-exact
        wait_slot(3);
        push(16'h8000);
        repeat (2 * FRAME) @(negedge clk_in);

        // full FIFO, push coincident with pop
        wait_slot(2);
        push(16'h0010); push(16'h0020); push(16'h0030); push(16'h0040);
        push_at_frame_start(16'h0050);
        repeat (6 * FRAME) @(negedge clk_in);

        // empty FIFO, push coincident with pop: mute now, sample next frame
        push_at_frame_start(16'h0066);
        repeat (3 * FRAME) @(negedge clk_in);

        // reset mid-frame with two entries queued
        wait_slot(28);
        push(16'h1111); push(16'h2222); push(16'h3333);
        wait_slot(10);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (2 * FRAME) @(negedge clk_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
